// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N producers.
// Grants one producer at a time for a burst of up to BURST pushes, stalling on fifo_full.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int BURST = 4,
  localparam int IW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] data,
  input  logic            fifo_full,
  output logic [N-1:0]    gnt,
  output logic            wr_en,
  output logic [DW-1:0]   wr_data,
  output logic [IW-1:0]   owner,
  output logic            busy
);

  localparam int          CW = $clog2(BURST + 1);
  localparam int unsigned NU = N;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t        r_state, w_state_nx;
  logic [IW-1:0] r_rr_ptr, w_rr_ptr_nx;
  logic [IW-1:0] r_owner, w_owner_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [IW-1:0] w_pick, w_owner_inc;
  logic          w_found, w_push;

  // First requester at or after r_rr_ptr, wrapping modulo N.
  always_comb begin : pick
    int unsigned v_idx;
    w_pick  = '0;
    w_found = 1'b0;
    v_idx   = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      v_idx = (32'(r_rr_ptr) + k) % NU;
      if (!w_found && req[v_idx]) begin
        w_found = 1'b1;
        w_pick  = IW'(v_idx);
      end
    end
  end

  assign w_owner_inc = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;
  assign w_push      = (r_state == S_BUSY) && req[r_owner] && !fifo_full;

  always_comb begin
    gnt     = '0;
    wr_data = '0;
    wr_en   = w_push;
    busy    = (r_state == S_BUSY);
    owner   = r_owner;
    if (w_push) begin
      gnt[r_owner] = 1'b1;
      wr_data      = data[r_owner*DW +: DW];
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_rr_ptr_nx = r_rr_ptr;
    w_owner_nx  = r_owner;
    w_cnt_nx    = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nx = w_pick;
          w_cnt_nx   = '0;
          w_state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!req[r_owner]) begin
          w_state_nx  = S_IDLE;
          w_rr_ptr_nx = w_owner_inc;
        end else if (w_push) begin
          if (r_cnt == CW'(BURST - 1)) begin
            w_state_nx  = S_IDLE;
            w_rr_ptr_nx = w_owner_inc;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_rr_ptr <= w_rr_ptr_nx;
      r_owner  <= w_owner_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle behavioural model plus
// directed scenarios with hand-computed traces and a 16-deep FIFO integration run.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int IW    = $clog2(N);
  localparam int DEPTH = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic            fifo_full;
  logic [N-1:0]    gnt;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic [IW-1:0]   owner;
  logic            busy;

  fifo_wr_arbiter #(.N(N), .DW(DW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .fifo_full(fifo_full),
    .gnt(gnt), .wr_en(wr_en), .wr_data(wr_data), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Producer word lists: producer i offers pw[i][pi[i]] while pi[i] < pn[i].
  logic [DW-1:0] pw [N][0:31];
  int            pn [N];
  int            pi [N];

  // Bench FIFO for the integration run.
  logic [DW-1:0] fq[$];
  bit            fifo_en = 0;
  int            cyc     = 0;
  int            ri [N];
  int            n_rx    = 0;

  int tr_gnt[$];
  int tr_wd[$];
  int tr_own[$];
  int tr_busy[$];

  // Model: who owns the write port and how many words it has pushed this grant.
  bit m_busy;
  int m_owner, m_done, m_next;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_owner = 0; m_done = 0; m_next = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        bit found;
        found = 0;
        for (int k = 0; k < N; k++)
          if (!found && req[(m_next + k) % N]) begin
            found = 1;
            m_owner = (m_next + k) % N;
          end
        m_busy = 1;
        m_done = 0;
      end
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_next = (m_owner + 1) % N;
    end else if (!fifo_full) begin
      m_done++;
      if (m_done == BURST) begin
        m_busy = 0;
        m_next = (m_owner + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0]  e_gnt;
    logic [DW-1:0] e_wd;
    bit            e_push;
    e_push = rst && m_busy && req[m_owner] && !fifo_full;
    e_gnt  = '0;
    e_wd   = '0;
    if (e_push) begin
      e_gnt[m_owner] = 1'b1;
      e_wd = data[m_owner*DW +: DW];
    end
    chk("cmp_gnt", int'(gnt), int'(e_gnt));
    chk("cmp_wr_en", int'(wr_en), int'(e_push));
    chk("cmp_wr_data", int'(wr_data), int'(e_wd));
    chk("cmp_busy", int'(busy), int'(rst && m_busy));
    if (rst && m_busy) chk("cmp_owner", int'(owner), m_owner);
  end

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req[i] = (pi[i] < pn[i]);
      data[i*DW +: DW] = req[i] ? pw[i][pi[i]] : '0;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      pn[i] = 0; pi[i] = 0; ri[i] = 0;
    end
    fq.delete();
    fifo_en = 0;
    fifo_full = 1'b0;
    drive_inputs();
  endtask

  task automatic clear_trace();
    tr_gnt.delete(); tr_wd.delete(); tr_own.delete(); tr_busy.delete();
  endtask

  // One clock: sample outputs mid-cycle, apply the resulting handshakes after the edge.
  task automatic step();
    logic [N-1:0]  s_gnt;
    logic          s_we;
    logic [DW-1:0] s_wd;
    logic [DW-1:0] w;
    int            pid;
    @(negedge clk);
    s_gnt = gnt; s_we = wr_en; s_wd = wr_data;
    tr_gnt.push_back(int'(gnt));
    tr_wd.push_back(int'(wr_data));
    tr_own.push_back(int'(owner));
    tr_busy.push_back(int'(busy));
    @(posedge clk);
    #1;
    if (fifo_en) begin
      if ((cyc % 2 == 1) && fq.size() > 0) begin
        w = fq.pop_front();
        pid = int'(w[DW-1 -: 2]);
        if (pid < 3 && ri[pid] < pn[pid]) begin
          chk("t6_order", int'(w), int'(pw[pid][ri[pid]]));
          ri[pid]++;
        end else begin
          chk("t6_unexpected_word", int'(w), -1);
        end
        n_rx++;
      end
      if (s_we) begin
        chk("t6_push_while_full", int'(fifo_full), 0);
        fq.push_back(s_wd);
        chk("t6_depth", int'(fq.size() <= DEPTH), 1);
      end
      fifo_full = (fq.size() >= DEPTH);
    end
    for (int i = 0; i < N; i++) if (s_gnt[i]) pi[i]++;
    drive_inputs();
    cyc++;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_trace();
  endtask

  initial begin
    int e1g[8]  = '{0, 2, 2, 2, 2, 0, 2, 2};
    int e1d[8]  = '{0, 'h11, 'h12, 'h13, 'h14, 0, 'h15, 'h16};
    int e3g[9]  = '{0, 4, 0, 0, 0, 4, 4, 4, 0};
    int e4g[12] = '{0, 1, 1, 0, 0, 2, 2, 2, 2, 0, 2, 2};
    int npush, k;

    rst = 1'b0;
    req = '0;
    data = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin pn[i] = 0; pi[i] = 0; ri[i] = 0; end
    #2;
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_busy", int'(busy), 0);

    // 1: single producer, six words -> 4-push burst, idle gap, 2 more.
    reset_dut();
    pn[1] = 6;
    for (int j = 0; j < 6; j++) pw[1][j] = 8'(8'h11 + j);
    drive_inputs();
    for (int c = 0; c < 8; c++) step();
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("t1_gnt[%0d]", c), tr_gnt[c], e1g[c]);
      chk($sformatf("t1_wd[%0d]", c), tr_wd[c], e1d[c]);
    end
    repeat (2) step();

    // 2: all request -> owners rotate 0,1,2,3,0 with one idle cycle per burst.
    reset_dut();
    for (int i = 0; i < N; i++) begin
      pn[i] = 8;
      for (int j = 0; j < 8; j++) pw[i][j] = 8'(i * 16 + j);
    end
    drive_inputs();
    for (int c = 0; c < 25; c++) step();
    npush = 0;
    for (int c = 0; c < 20; c++) if (tr_gnt[c] != 0) npush++;
    chk("t2_pushes_in_20", npush, 16);
    k = 0;
    for (int c = 0; c < 25; c++)
      if (tr_gnt[c] != 0) begin
        if (k < 20) chk($sformatf("t2_owner_push%0d", k), tr_own[c], (k / 4) % 4);
        k++;
      end
    chk("t2_total_pushes", k, 20);

    // 3: owner 2 stalls on fifo_full for 3 cycles after its first push.
    reset_dut();
    pn[2] = 4;
    for (int j = 0; j < 4; j++) pw[2][j] = 8'(8'hA0 + j);
    drive_inputs();
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 2 && c <= 4);
      step();
    end
    fifo_full = 1'b0;
    for (int c = 0; c < 9; c++) chk($sformatf("t3_gnt[%0d]", c), tr_gnt[c], e3g[c]);
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("t3_stall_owner[%0d]", c), tr_own[c], 2);
      chk($sformatf("t3_stall_busy[%0d]", c), tr_busy[c], 1);
    end

    // 4: owner 0 releases after 2 pushes; producer 1 then gets a full burst.
    reset_dut();
    pn[0] = 2; pn[1] = 6;
    for (int j = 0; j < 6; j++) begin pw[0][j] = 8'(8'h30 + j); pw[1][j] = 8'(8'h40 + j); end
    drive_inputs();
    for (int c = 0; c < 12; c++) step();
    for (int c = 0; c < 12; c++) chk($sformatf("t4_gnt[%0d]", c), tr_gnt[c], e4g[c]);
    chk("t4_release_busy", tr_busy[3], 1);
    chk("t4_idle_busy", tr_busy[4], 0);

    // 5: asynchronous reset mid-burst, then producer 3 alone.
    reset_dut();
    for (int i = 0; i < N; i++) begin
      pn[i] = 8;
      for (int j = 0; j < 8; j++) pw[i][j] = 8'(8'h50 + i);
    end
    drive_inputs();
    repeat (3) step();
    chk("t5_pre_gnt", int'(gnt), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_gnt", int'(gnt), 0);
    chk("t5_async_wr_en", int'(wr_en), 0);
    chk("t5_async_busy", int'(busy), 0);
    clear_all();
    pn[3] = 3;
    for (int j = 0; j < 3; j++) pw[3][j] = 8'(8'hC0 + j);
    drive_inputs();
    step();
    rst = 1'b1;
    clear_trace();
    repeat (3) step();
    chk("t5_idle_gnt", tr_gnt[0], 0);
    chk("t5_idle_busy", tr_busy[0], 0);
    chk("t5_gnt", tr_gnt[1], 8);
    chk("t5_owner", tr_own[1], 3);

    // 6: three producers into the 16-deep FIFO, reader draining every other cycle.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      pn[i] = 10;
      for (int j = 0; j < 10; j++) pw[i][j] = {2'(i), 6'($urandom_range(0, 63))};
    end
    fifo_en = 1;
    cyc = 0;
    n_rx = 0;
    drive_inputs();
    for (int c = 0; c < 2000 && n_rx < 30; c++) step();
    chk("t6_words_out", n_rx, 30);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_read_p%0d", i), ri[i], 10);
      chk($sformatf("t6_sent_p%0d", i), pi[i], 10);
    end
    chk("t6_fifo_empty", fq.size(), 0);
    fifo_en = 0;
    fifo_full = 1'b0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
